// File: rtl/i2c_mon_pkg.sv
// i2c_mon_pkg: shared definitions for the I2C bus monitor.
//   - parameter defaults for synchroniser depth, filter length, timeout width
//   - err_o bit indices
//   - monitor FSM state encoding
//   - saturating byte-counter increment helper
package i2c_mon_pkg;

    localparam int SYNC_STAGES_DEF = 2;
    localparam int FILT_LEN_DEF    = 3;
    localparam int TO_W_DEF        = 16;

    localparam int ERR_MISPLACED = 0;  // START/STOP in the middle of a byte
    localparam int ERR_SCL_TO    = 1;  // SCL held low too long while busy
    localparam int ERR_TIP_TO    = 2;  // core transfer pending on an idle bus
    localparam int ERR_GLITCH    = 3;  // short pulse rejected by a filter

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_ACKB = 2'd2
    } mon_state_e;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/i2c_mon_filter.sv
// i2c_mon_filter: synchroniser plus glitch filter for one raw bus line.
//   clk_i    : monitor clock
//   rst_ni   : asynchronous active-low reset (outputs reset to 1 / 0)
//   pad_i    : raw asynchronous bus line
//   lvl_o    : filtered level; follows the synchronised line only after
//              FILT_LEN consecutive samples that differ from the current level
//   glitch_o : one-cycle pulse when a differing run ends before FILT_LEN samples
module i2c_mon_filter
    import i2c_mon_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int FILT_LEN    = FILT_LEN_DEF
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic pad_i,
    output logic lvl_o,
    output logic glitch_o
);

    localparam int CW = $clog2(FILT_LEN + 1);
    localparam logic [CW-1:0] RUN_MAX = CW'(FILT_LEN - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_s;
    logic                   lvl_q, lvl_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   glitch_q, glitch_d;

    assign sync_s = sync_q[SYNC_STAGES-1];

    // Synchroniser chain; idles high like an undriven I2C line.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pad_i};
        end
    end

    // Run-length filter: cnt_q counts consecutive samples differing from lvl_q.
    always_comb begin
        lvl_d    = lvl_q;
        cnt_d    = cnt_q;
        glitch_d = 1'b0;
        if (sync_s != lvl_q) begin
            if (cnt_q == RUN_MAX) begin
                lvl_d = sync_s;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else begin
            // A run that ends without being accepted was a glitch.
            if (cnt_q != '0) begin
                glitch_d = 1'b1;
            end else begin
                glitch_d = 1'b0;
            end
            cnt_d = '0;
        end
    end

    // Filter state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lvl_q    <= 1'b1;
            cnt_q    <= '0;
            glitch_q <= 1'b0;
        end else begin
            lvl_q    <= lvl_d;
            cnt_q    <= cnt_d;
            glitch_q <= glitch_d;
        end
    end

    assign lvl_o    = lvl_q;
    assign glitch_o = glitch_q;

endmodule

// File: rtl/i2c_bus_monitor.sv
// i2c_bus_monitor: passive I2C bus observer.
//   wb_clk_i, arst_ni        : clock, asynchronous active-low reset
//   scl_pad_i, sda_pad_i     : raw bus lines
//   tip                      : core transfer-in-progress flag
//   en_i, clr_i, timeout_i   : enable, clear of sticky state, timeout (0 = off)
//   start_o/rstart_o/stop_o  : one-cycle bus condition pulses
//   byte_vld_o/byte_o/ack_o  : completed byte with its ACK (1) / NACK (0)
//   busy_o, byte_cnt_o       : bus owned; bytes since last (repeated) START
//   err_o                    : sticky errors, indices in i2c_mon_pkg
module i2c_bus_monitor
    import i2c_mon_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int FILT_LEN    = FILT_LEN_DEF,
    parameter int TO_W        = TO_W_DEF
) (
    input  logic            wb_clk_i,
    input  logic            arst_ni,
    input  logic            scl_pad_i,
    input  logic            sda_pad_i,
    input  logic            tip,
    input  logic            en_i,
    input  logic            clr_i,
    input  logic [TO_W-1:0] timeout_i,
    output logic            start_o,
    output logic            rstart_o,
    output logic            stop_o,
    output logic            byte_vld_o,
    output logic [7:0]      byte_o,
    output logic            ack_o,
    output logic            busy_o,
    output logic [7:0]      byte_cnt_o,
    output logic [3:0]      err_o
);

    logic scl_f_s, sda_f_s, scl_gl_s, sda_gl_s;

    i2c_mon_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_scl_filt (
        .clk_i(wb_clk_i), .rst_ni(arst_ni), .pad_i(scl_pad_i),
        .lvl_o(scl_f_s), .glitch_o(scl_gl_s)
    );

    i2c_mon_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_sda_filt (
        .clk_i(wb_clk_i), .rst_ni(arst_ni), .pad_i(sda_pad_i),
        .lvl_o(sda_f_s), .glitch_o(sda_gl_s)
    );

    mon_state_e      state_q, state_d;
    logic            scl_p_q, sda_p_q;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [2:0]      prev_cnt_q, prev_cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      byte_q, byte_d;
    logic            ack_q, ack_d;
    logic            start_q, start_d, rstart_q, rstart_d, stop_q, stop_d;
    logic            vld_q, vld_d, busy_q, busy_d;
    logic [7:0]      byte_cnt_q, byte_cnt_d;
    logic [3:0]      err_q, err_d, err_set_s;
    logic [TO_W-1:0] scl_to_q, scl_to_d, tip_to_q, tip_to_d;

    logic scl_rise_s, start_det_s, stop_det_s, misplaced_s;
    logic to_en_s, scl_cond_s, tip_cond_s, scl_hit_s, tip_hit_s;

    // SCL must be stable high across both cycles, so a simultaneous SCL/SDA
    // change is treated purely as an SCL edge.
    assign scl_rise_s  = scl_f_s & ~scl_p_q;
    assign start_det_s = ~sda_f_s & sda_p_q & scl_f_s & scl_p_q;
    assign stop_det_s  = sda_f_s & ~sda_p_q & scl_f_s & scl_p_q;
    // A START/STOP follows the SCL rise that already counted a tentative bit,
    // so misplacement is judged on the count before that rise.
    assign misplaced_s = (state_q != ST_IDLE) && (prev_cnt_q != 3'd0);

    assign to_en_s    = en_i && (timeout_i != '0);
    assign scl_cond_s = to_en_s && busy_q && !scl_f_s;
    assign tip_cond_s = to_en_s && tip && !busy_q;
    assign scl_hit_s  = scl_cond_s && (scl_to_q == timeout_i - TO_W'(1));
    assign tip_hit_s  = tip_cond_s && (tip_to_q == timeout_i - TO_W'(1));

    // Timeout counters saturate at the threshold so the error fires once.
    always_comb begin
        scl_to_d = '0;
        tip_to_d = '0;
        if (scl_cond_s && (scl_to_q < timeout_i)) begin
            scl_to_d = scl_to_q + TO_W'(1);
        end else if (scl_cond_s) begin
            scl_to_d = scl_to_q;
        end else begin
            scl_to_d = '0;
        end
        if (tip_cond_s && (tip_to_q < timeout_i)) begin
            tip_to_d = tip_to_q + TO_W'(1);
        end else if (tip_cond_s) begin
            tip_to_d = tip_to_q;
        end else begin
            tip_to_d = '0;
        end
    end

    // Monitor FSM next-state and output logic.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        prev_cnt_d = prev_cnt_q;
        shift_d    = shift_q;
        byte_d     = byte_q;
        ack_d      = ack_q;
        start_d    = 1'b0;
        rstart_d   = 1'b0;
        stop_d     = 1'b0;
        vld_d      = 1'b0;
        err_set_s  = 4'b0000;
        byte_cnt_d = clr_i ? 8'd0 : byte_cnt_q;
        err_d      = clr_i ? 4'b0000 : err_q;
        if (!en_i) begin
            state_d    = ST_IDLE;
            bit_cnt_d  = 3'd0;
            prev_cnt_d = 3'd0;
        end else begin
            if (start_det_s) begin
                if (state_q == ST_IDLE) begin
                    start_d = 1'b1;
                end else begin
                    rstart_d = 1'b1;
                end
                err_set_s[ERR_MISPLACED] = misplaced_s;
                state_d    = ST_DATA;
                bit_cnt_d  = 3'd0;
                prev_cnt_d = 3'd0;
                byte_cnt_d = 8'd0;
            end else if (stop_det_s) begin
                stop_d     = 1'b1;
                err_set_s[ERR_MISPLACED] = misplaced_s;
                state_d    = ST_IDLE;
                bit_cnt_d  = 3'd0;
                prev_cnt_d = 3'd0;
            end else if (scl_rise_s) begin
                case (state_q)
                    ST_DATA: begin
                        shift_d    = {shift_q[6:0], sda_f_s};
                        prev_cnt_d = bit_cnt_q;
                        bit_cnt_d  = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_d = ST_ACKB;
                        end else begin
                            state_d = ST_DATA;
                        end
                    end
                    ST_ACKB: begin
                        byte_d     = shift_q;
                        ack_d      = ~sda_f_s;
                        vld_d      = 1'b1;
                        byte_cnt_d = sat_inc8(byte_cnt_d);
                        prev_cnt_d = 3'd0;
                        state_d    = ST_DATA;
                    end
                    default: begin
                        state_d = ST_IDLE;
                    end
                endcase
            end else begin
                state_d = state_q;
            end
            err_set_s[ERR_SCL_TO] = scl_hit_s;
            err_set_s[ERR_TIP_TO] = tip_hit_s;
            err_set_s[ERR_GLITCH] = scl_gl_s | sda_gl_s;
        end
        // A newly detected error survives a clear in the same cycle.
        err_d  = err_d | err_set_s;
        busy_d = (state_d != ST_IDLE);
    end

    // All monitor state and registered outputs.
    always_ff @(posedge wb_clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state_q    <= ST_IDLE;
            scl_p_q    <= 1'b1;
            sda_p_q    <= 1'b1;
            bit_cnt_q  <= 3'd0;
            prev_cnt_q <= 3'd0;
            shift_q    <= 8'd0;
            byte_q     <= 8'd0;
            ack_q      <= 1'b0;
            start_q    <= 1'b0;
            rstart_q   <= 1'b0;
            stop_q     <= 1'b0;
            vld_q      <= 1'b0;
            busy_q     <= 1'b0;
            byte_cnt_q <= 8'd0;
            err_q      <= 4'b0000;
            scl_to_q   <= '0;
            tip_to_q   <= '0;
        end else begin
            state_q    <= state_d;
            scl_p_q    <= scl_f_s;
            sda_p_q    <= sda_f_s;
            bit_cnt_q  <= bit_cnt_d;
            prev_cnt_q <= prev_cnt_d;
            shift_q    <= shift_d;
            byte_q     <= byte_d;
            ack_q      <= ack_d;
            start_q    <= start_d;
            rstart_q   <= rstart_d;
            stop_q     <= stop_d;
            vld_q      <= vld_d;
            busy_q     <= busy_d;
            byte_cnt_q <= byte_cnt_d;
            err_q      <= err_d;
            scl_to_q   <= scl_to_d;
            tip_to_q   <= tip_to_d;
        end
    end

    assign start_o    = start_q;
    assign rstart_o   = rstart_q;
    assign stop_o     = stop_q;
    assign byte_vld_o = vld_q;
    assign byte_o     = byte_q;
    assign ack_o      = ack_q;
    assign busy_o     = busy_q;
    assign byte_cnt_o = byte_cnt_q;
    assign err_o      = err_q;

endmodule

// File: tb/tb_i2c_bus_monitor.sv
// Directed bench for i2c_bus_monitor with default parameters.
module tb_i2c_bus_monitor;

    localparam int H = 8;  // cycles per bus half-phase, longer than the 6-cycle latency

    logic        clk = 1'b0;
    logic        arst_n = 1'b0;
    logic        scl = 1'b1, sda = 1'b1, tip = 1'b0, en = 1'b1, clr = 1'b0;
    logic [15:0] timeout = 16'd0;
    logic        start_o, rstart_o, stop_o, byte_vld_o, ack_o, busy_o;
    logic [7:0]  byte_o, byte_cnt_o;
    logic [3:0]  err_o;

    int n_cmp = 0;
    int n_bad = 0;
    int n_start = 0, n_rstart = 0, n_stop = 0, n_vld = 0;
    logic [7:0] last_byte = 8'h00;
    logic       last_ack = 1'b0;

    i2c_bus_monitor dut (
        .wb_clk_i(clk), .arst_ni(arst_n), .scl_pad_i(scl), .sda_pad_i(sda),
        .tip(tip), .en_i(en), .clr_i(clr), .timeout_i(timeout),
        .start_o(start_o), .rstart_o(rstart_o), .stop_o(stop_o),
        .byte_vld_o(byte_vld_o), .byte_o(byte_o), .ack_o(ack_o),
        .busy_o(busy_o), .byte_cnt_o(byte_cnt_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    // Pulse bookkeeping on the inactive edge.
    always @(negedge clk) begin
        if (start_o)  n_start  <= n_start + 1;
        if (rstart_o) n_rstart <= n_rstart + 1;
        if (stop_o)   n_stop   <= n_stop + 1;
        if (byte_vld_o) begin
            n_vld     <= n_vld + 1;
            last_byte <= byte_o;
            last_ack  <= ack_o;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_start();
        sda = 1'b0; wait_cyc(H);
        scl = 1'b0; wait_cyc(H);
    endtask

    task automatic bus_rstart();
        sda = 1'b1; wait_cyc(H);
        scl = 1'b1; wait_cyc(H);
        sda = 1'b0; wait_cyc(H);
        scl = 1'b0; wait_cyc(H);
    endtask

    task automatic bus_stop();
        sda = 1'b0; wait_cyc(H);
        scl = 1'b1; wait_cyc(H);
        sda = 1'b1; wait_cyc(H);
    endtask

    task automatic bus_bit(input logic b);
        sda = b;    wait_cyc(H);
        scl = 1'b1; wait_cyc(H);
        scl = 1'b0; wait_cyc(H);
    endtask

    task automatic bus_byte(input logic [7:0] b, input logic ack);
        for (int i = 7; i >= 0; i--) bus_bit(b[i]);
        bus_bit(~ack);
    endtask

    task automatic pulse_clr();
        clr = 1'b1; wait_cyc(1);
        clr = 1'b0; wait_cyc(1);
    endtask

    initial begin
        // Reset state
        wait_cyc(3);
        check("rst_busy", busy_o, 0);
        check("rst_err", err_o, 0);
        check("rst_bcnt", byte_cnt_o, 0);
        check("rst_pulses", {start_o, rstart_o, stop_o, byte_vld_o, ack_o}, 0);
        arst_n = 1'b1;
        wait_cyc(10);

        // Address 0xA4 ACK, data 0x5A NACK
        bus_start();
        check("t1_start", n_start, 1);
        check("t1_busy", busy_o, 1);
        bus_byte(8'hA4, 1'b1);
        check("t1_b0", {n_vld[7:0], last_byte, 7'd0, last_ack}, {8'd1, 8'hA4, 8'd1});
        bus_byte(8'h5A, 1'b0);
        check("t1_b1", {n_vld[7:0], last_byte, 7'd0, last_ack}, {8'd2, 8'h5A, 8'd0});
        bus_stop();
        check("t1_stop", n_stop, 1);
        check("t1_bcnt", byte_cnt_o, 2);
        check("t1_err", err_o, 0);
        check("t1_idle", busy_o, 0);

        // Repeated START
        bus_start();
        bus_byte(8'h11, 1'b1);
        bus_rstart();
        check("t2_rstart", n_rstart, 1);
        check("t2_bcnt_rs", byte_cnt_o, 0);
        bus_byte(8'h22, 1'b1);
        check("t2_start", n_start, 2);
        check("t2_bcnt", byte_cnt_o, 1);
        check("t2_byte", last_byte, 8'h22);
        bus_stop();
        check("t2_err", err_o, 0);

        // STOP after 4 data bits
        bus_start();
        bus_bit(1'b1); bus_bit(1'b0); bus_bit(1'b1); bus_bit(1'b1);
        bus_stop();
        check("t3_stop", n_stop, 3);
        check("t3_err", err_o, 4'b0001);
        check("t3_idle", busy_o, 0);
        check("t3_novld", n_vld, 4);
        pulse_clr();
        check("t3_clr", err_o, 0);

        // SCL-low timeout mid-byte
        timeout = 16'd100;
        bus_start();
        bus_bit(1'b1); bus_bit(1'b0);
        scl = 1'b1; wait_cyc(H);
        scl = 1'b0;
        wait_cyc(104);
        check("t4_to_early", err_o, 0);
        wait_cyc(1);
        check("t4_to_hit", err_o, 4'b0010);
        check("t4_busy", busy_o, 1);
        pulse_clr();
        check("t4_clr", err_o, 0);
        bus_stop();
        check("t4_stop_mis", err_o, 4'b0001);
        pulse_clr();

        // tip held on an idle bus
        timeout = 16'd10;
        tip = 1'b1;
        wait_cyc(9);
        check("t4_tip_early", err_o, 0);
        wait_cyc(1);
        check("t4_tip_hit", err_o, 4'b0100);
        tip = 1'b0;
        timeout = 16'd0;
        pulse_clr();
        check("t4_tip_clr", err_o, 0);

        // Glitch rejection and START latency
        sda = 1'b0; wait_cyc(2);
        sda = 1'b1; wait_cyc(10);
        check("t5_glitch", err_o, 4'b1000);
        check("t5_nostart", n_start, 4);
        pulse_clr();
        sda = 1'b0; wait_cyc(3);
        sda = 1'b1; wait_cyc(2);
        check("t5_lat5", start_o, 0);
        wait_cyc(1);
        check("t5_lat6", start_o, 1);
        wait_cyc(12);
        check("t5_cnt", {n_start[7:0], n_stop[7:0]}, {8'd5, 8'd5});
        check("t5_err", err_o, 0);

        // Reset after bit 5
        bus_start();
        bus_bit(1'b1); bus_bit(1'b0); bus_bit(1'b1); bus_bit(1'b1); bus_bit(1'b1);
        arst_n = 1'b0;
        wait_cyc(2);
        check("t6_rst_out", {busy_o, byte_cnt_o, err_o, byte_o, ack_o}, 0);
        arst_n = 1'b1;
        wait_cyc(H);
        scl = 1'b1;
        wait_cyc(12);
        check("t6_quiet", {n_start[7:0], n_stop[7:0], n_vld[7:0]}, {8'd6, 8'd5, 8'd4});
        bus_start();
        bus_byte(8'hC3, 1'b1);
        check("t6_byte", {last_byte, 7'd0, last_ack}, {8'hC3, 8'd1});
        check("t6_bcnt", byte_cnt_o, 1);
        bus_stop();
        check("t6_end", {n_start[7:0], n_stop[7:0], n_vld[7:0], 4'd0, err_o}, {8'd7, 8'd6, 8'd5, 8'd0});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
